// File: rtl/sevenseg_disp_arbiter_if.sv
// Requester/display bundle shared between the two sources and the arbiter.
// The master side drives requests, digit codes and tick; the slave side drives grants and digits.
interface sevenseg_disp_arbiter_if;
  logic        tick;
  logic        req0;
  logic        req1;
  logic [41:0] r0_digits;
  logic [41:0] r1_digits;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic [6:0]  d0;
  logic [6:0]  d1;
  logic [6:0]  d2;
  logic [6:0]  d3;
  logic [6:0]  d4;
  logic [6:0]  d5;

  modport master (
    output tick, req0, req1, r0_digits, r1_digits,
    input  gnt0, gnt1, busy, d0, d1, d2, d3, d4, d5
  );

  modport slave (
    input  tick, req0, req1, r0_digits, r1_digits,
    output gnt0, gnt1, busy, d0, d1, d2, d3, d4, d5
  );
endinterface

// File: rtl/sevenseg_disp_arbiter.sv
// Two-source arbiter for the six-digit seven-segment display.
// Enforces a minimum hold and a contention timeslice counted in ticks.
module sevenseg_disp_arbiter #(
  parameter int         MIN_HOLD  = 2,
  parameter int         MAX_HOLD  = 8,
  parameter logic [6:0] IDLE_CODE = 7'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  sevenseg_disp_arbiter_if.slave bus
);

  localparam int              CW     = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]   MINH   = CW'(MIN_HOLD);
  localparam logic [CW-1:0]   MAXH   = CW'(MAX_HOLD);
  localparam logic [41:0]     IDLE_W = {6{IDLE_CODE}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          r_last;
  logic          w_last;
  logic [41:0]   r_dig;
  logic [41:0]   w_dig;
  logic          w_min;
  logic          w_slice;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_dig   <= IDLE_W;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_dig   <= w_dig;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_last  = r_last;
    w_min   = (r_cnt >= MINH);
    w_slice = (r_cnt >= MAXH);
    unique case (r_state)
      S_IDLE: begin
        if (bus.req0 && bus.req1)
          w_next = r_last ? S_GNT0 : S_GNT1;
        else if (bus.req0)
          w_next = S_GNT0;
        else if (bus.req1)
          w_next = S_GNT1;
      end
      S_GNT0: begin
        if (bus.req0) begin
          if (w_slice && bus.req1) begin
            w_next = S_GNT1;
            w_last = 1'b0;
          end
        end else if (w_min) begin
          w_next = bus.req1 ? S_GNT1 : S_IDLE;
          w_last = 1'b0;
        end
      end
      S_GNT1: begin
        if (bus.req1) begin
          if (w_slice && bus.req0) begin
            w_next = S_GNT0;
            w_last = 1'b1;
          end
        end else if (w_min) begin
          w_next = bus.req0 ? S_GNT0 : S_IDLE;
          w_last = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // New owner loads immediately; an owner that dropped its request freezes.
  always_comb begin
    w_dig = r_dig;
    unique case (w_next)
      S_GNT0: if (r_state != S_GNT0 || bus.req0) w_dig = bus.r0_digits;
      S_GNT1: if (r_state != S_GNT1 || bus.req1) w_dig = bus.r1_digits;
      default: w_dig = IDLE_W;
    endcase
  end

  always_comb begin
    w_cnt = r_cnt;
    if (w_next != r_state)
      w_cnt = '0;
    else if (r_state != S_IDLE && bus.tick && !w_slice)
      w_cnt = r_cnt + 1'b1;
  end

  assign bus.gnt0 = (r_state == S_GNT0);
  assign bus.gnt1 = (r_state == S_GNT1);
  assign bus.busy = (r_state != S_IDLE);
  assign bus.d0   = r_dig[6:0];
  assign bus.d1   = r_dig[13:7];
  assign bus.d2   = r_dig[20:14];
  assign bus.d3   = r_dig[27:21];
  assign bus.d4   = r_dig[34:28];
  assign bus.d5   = r_dig[41:35];

endmodule

// File: doc/sevenseg_disp_arbiter.md
Name: sevenseg_disp_arbiter

Overview:
Shares the six-digit seven-segment display between two requesters, for example a status/clock source and an alert/message source. Each requester presents six 7-bit digit codes and a request. The block grants the display to one requester at a time, enforces a minimum on-screen hold time and a maximum timeslice under contention, and drives registered d0..d5 into the display multiplex controller. The hold timing uses an external one-cycle tick from the existing period enable generator.

Parameters:
MIN_HOLD, 2, minimum ticks a granted source stays on screen; 0 means release is allowed immediately.
MAX_HOLD, 8, ticks after which a still-requesting source yields to a pending other requester; must be >= MIN_HOLD and >= 1.
IDLE_CODE, 7'd0, digit code driven on all six digits when no source is granted.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
tick  input  1  one-cycle timing enable (period enable output); hold counting uses only these pulses.
req0  input  1  requester 0 wants the display.
req1  input  1  requester 1 wants the display.
r0_digits  input  42  requester 0 digit codes; [6:0]=digit0 ... [41:35]=digit5.
r1_digits  input  42  requester 1 digit codes, same packing.
gnt0  output  1  requester 0 owns the display.
gnt1  output  1  requester 1 owns the display.
busy  output  1  gnt0 | gnt1.
d0..d5  output  7 each  registered digit codes to the display controller.

Behaviour:
- Reset (async, immediate): state=IDLE; gnt0=gnt1=busy=0; d0..d5=IDLE_CODE; hold count=0; last_served=1, so req0 wins the first tie.
- States: IDLE, GNT0, GNT1. gnt0/gnt1 are decoded from the state register. They are never both 1.
- All registers (state, count, digits) update on the same clk edge. d0..d5 load from the next-state owner, so grant and new digits appear together one cycle after the request is sampled.
- IDLE:
  - req0 only -> GNT0.
  - req1 only -> GNT1.
  - Both -> the requester that is not last_served.
  - Neither -> stay in IDLE; digits remain IDLE_CODE.
- Hold counter: cleared on every grant change, including entry from IDLE. Increments on tick while in GNTx. Saturates at MAX_HOLD. min_done = (count >= MIN_HOLD). slice_done = (count >= MAX_HOLD).
- GNTx, with y denoting the other requester:
  - reqx=1, and (not slice_done or reqy=0) -> stay. Digits reload from rx_digits every cycle (live update).
  - reqx=1, slice_done, reqy=1 -> switch to GNTy. Set last_served=x.
  - reqx=0, not min_done -> stay. Digits freeze at their last loaded values. The counter keeps counting ticks.
  - reqx=0, min_done, reqy=1 -> GNTy. Set last_served=x.
  - reqx=0, min_done, reqy=0 -> IDLE. Set last_served=x. Digits go to IDLE_CODE on the same edge.
- A requester that re-asserts during its own frozen hold period resumes live updates with no change of grant.
- tick in the same cycle as a transition: the counter is cleared, and that tick is not counted toward the new owner.
- MIN_HOLD=0: release is allowed on the first cycle with reqx=0.
- Under continuous contention the grant alternates every MAX_HOLD ticks. Neither requester starves.
- Reset asserted mid-grant returns everything to reset values immediately, with no waiting for a clock edge.
- No combinational path from any input to any output.

Test Plan:
- Reset, then idle: rst pulse with no requests -> gnt0=gnt1=busy=0 and all d* = 7'd0 during and after reset.
- Single grant with live update: req1=1 with r1_digits digit0=7'h05 at cycle n -> gnt1=1 and d0=7'h05 at n+1. Change digit0 to 7'h06 -> d0=7'h06 the next cycle.
- Minimum hold: req0 granted, then dropped after 0 ticks -> gnt0 stays 1 and digits stay frozen until the 2nd tick after grant. gnt0=0 and d*=IDLE_CODE on the edge after that tick is counted.
- Tie and fairness: req0 and req1 rise together after reset -> GNT0. Drop req0 after min hold while req1 is still high -> GNT1 next cycle. Repeat the tie from IDLE -> GNT0, because last_served=1.
- Timeslice: both requests held high -> gnt0 for 8 ticks, then gnt1 for 8 ticks, alternating. gnt0 and gnt1 are never 1 simultaneously.
- Async reset mid-grant: assert rst between clock edges while in GNT1 -> gnt1=0 and d*=IDLE_CODE without a clk edge. After release with req0=req1=1 -> GNT0.
